// File: rtl/alu_seq_if.sv
// Request/response bundle for the sequential ALU.
// Master issues operations and consumes results; slave is the ALU.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       aluop;
  logic [WIDTH-1:0] alua;
  logic [WIDTH-1:0] alub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alur;
  logic             zero;
  logic             neg;
  logic             carry;
  logic             ovf;

  modport master (
    output in_valid, aluop, alua, alub, out_ready,
    input  in_ready, out_valid, alur, zero, neg, carry, ovf
  );

  modport slave (
    input  in_valid, aluop, alua, alub, out_ready,
    output in_ready, out_valid, alur, zero, neg, carry, ovf
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic ops, bit-serial shifts,
// shift-add multiply, with registered result and flags.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_SRA = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  localparam logic [SHW:0] CNT_W = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_1 = (SHW+1)'(1);

  state_t state_q, state_d;

  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [SHW:0]     cnt_q;
  logic             c_q;

  logic [WIDTH-1:0] r_q;
  logic             z_q;
  logic             n_q;
  logic             cf_q;
  logic             v_q;

  logic             fire;
  logic             is_sh;
  logic             is_mul;
  logic             go_exec;
  logic             last;
  logic [SHW:0]     amt;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;

  logic [WIDTH-1:0] res_s;
  logic             car_s;
  logic             ovf_s;

  logic [WIDTH-1:0] a_nx;
  logic [WIDTH-1:0] b_nx;
  logic [WIDTH-1:0] acc_nx;
  logic             c_nx;
  logic [WIDTH-1:0] fin;

  assign bus.in_ready  = (state_q == IDLE) & ~rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.alur      = r_q;
  assign bus.zero      = z_q;
  assign bus.neg       = n_q;
  assign bus.carry     = cf_q;
  assign bus.ovf       = v_q;

  assign fire    = bus.in_valid & bus.in_ready;
  assign amt     = {1'b0, bus.alub[SHW-1:0]};
  assign is_mul  = (bus.aluop == OP_MUL);
  assign is_sh   = (bus.aluop == OP_SLL) |
                   (bus.aluop == OP_SRL) |
                   (bus.aluop == OP_SRA);
  assign go_exec = is_mul | (is_sh & (amt != '0));
  assign last    = (cnt_q == CNT_1);

  assign sum = {1'b0, bus.alua} + {1'b0, bus.alub};
  assign dif = {1'b0, bus.alua} - {1'b0, bus.alub};

  // Ops that finish at the accepting edge; zero-length shifts pass A.
  always_comb begin
    res_s = sum[WIDTH-1:0];
    car_s = sum[WIDTH];
    ovf_s = (bus.alua[WIDTH-1] == bus.alub[WIDTH-1]) &
            (sum[WIDTH-1] != bus.alua[WIDTH-1]);
    unique case (bus.aluop)
      OP_SUB: begin
        res_s = dif[WIDTH-1:0];
        car_s = dif[WIDTH];
        ovf_s = (bus.alua[WIDTH-1] != bus.alub[WIDTH-1]) &
                (dif[WIDTH-1] != bus.alua[WIDTH-1]);
      end
      OP_AND: begin
        res_s = bus.alua & bus.alub;
        car_s = 1'b0;
        ovf_s = 1'b0;
      end
      OP_OR: begin
        res_s = bus.alua | bus.alub;
        car_s = 1'b0;
        ovf_s = 1'b0;
      end
      OP_XOR: begin
        res_s = bus.alua ^ bus.alub;
        car_s = 1'b0;
        ovf_s = 1'b0;
      end
      OP_NOT: begin
        res_s = ~bus.alua;
        car_s = 1'b0;
        ovf_s = 1'b0;
      end
      OP_SLL, OP_SRL, OP_SRA, OP_MUL: begin
        res_s = bus.alua;
        car_s = 1'b0;
        ovf_s = 1'b0;
      end
      default: begin
      end
    endcase
  end

  // One iteration step of the captured long operation.
  always_comb begin
    a_nx   = a_q;
    b_nx   = b_q;
    acc_nx = acc_q;
    c_nx   = c_q;
    unique case (op_q)
      OP_SLL: begin
        a_nx = a_q << 1;
        c_nx = a_q[WIDTH-1];
      end
      OP_SRL: begin
        a_nx = a_q >> 1;
        c_nx = a_q[0];
      end
      OP_SRA: begin
        a_nx = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
        c_nx = a_q[0];
      end
      OP_MUL: begin
        acc_nx = b_q[0] ? acc_q + a_q : acc_q;
        a_nx   = a_q << 1;
        b_nx   = b_q >> 1;
        c_nx   = 1'b0;
      end
      default: begin
      end
    endcase
  end

  assign fin = (op_q == OP_MUL) ? acc_nx : a_nx;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (fire) state_d = go_exec ? EXEC : DONE;
      EXEC: if (last) state_d = DONE;
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= OP_ADD;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      c_q   <= 1'b0;
      r_q   <= '0;
      z_q   <= 1'b0;
      n_q   <= 1'b0;
      cf_q  <= 1'b0;
      v_q   <= 1'b0;
    end else if (fire) begin
      op_q  <= bus.aluop;
      a_q   <= bus.alua;
      b_q   <= bus.alub;
      acc_q <= '0;
      c_q   <= 1'b0;
      cnt_q <= go_exec ? (is_mul ? CNT_W : amt) : '0;
      if (!go_exec) begin
        r_q  <= res_s;
        z_q  <= (res_s == '0);
        n_q  <= res_s[WIDTH-1];
        cf_q <= car_s;
        v_q  <= ovf_s;
      end
    end else if (state_q == EXEC) begin
      a_q   <= a_nx;
      b_q   <= b_nx;
      acc_q <= acc_nx;
      c_q   <= c_nx;
      cnt_q <= cnt_q - CNT_1;
      if (last) begin
        r_q  <= fin;
        z_q  <= (fin == '0);
        n_q  <= fin[WIDTH-1];
        cf_q <= c_nx;
        v_q  <= 1'b0;
      end
    end
  end

endmodule
